othello_turn_ctrl: RTL and testbench

- Parametrised turn sequencer for the board game engine. Supersedes the fixed two-player black/white controller.
- Supports NUM_PLAYERS players in round-robin order, explicit pass handling, all-players-passed game termination, a move counter and a restart path.
- Sits between the user/input layer (go), the move-validation datapath (ack, pass, game_end) and the board datapath (enable, player).

---
 rtl/othello_turn_ctrl.sv | 147 ++++++++++++++
 tb/tb_othello_turn_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/othello_turn_ctrl.sv
// othello_turn_ctrl: round-robin turn sequencer for NUM_PLAYERS players.
// Handles explicit passes, ends the game after all players pass in a row,
// counts accepted moves (saturating) and supports restart from game over.
// Optional build macro: OTHELLO_TURN_TIMEOUT_EN adds a per-turn timer that
// forces a pass after TIMEOUT_CYCLES idle cycles; without it timeout is 0.
module othello_turn_ctrl #(
    parameter int NUM_PLAYERS    = 2,
    parameter int PLAYER_W       = 1,
    parameter int MOVE_W         = 7,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    input  logic                ack,
    input  logic                pass,
    input  logic                game_end,
    output logic                enable,
    output logic [PLAYER_W-1:0] player,
    output logic                turn_start,
    output logic                game_over,
    output logic [MOVE_W-1:0]   move_count,
    output logic                timeout
);

    localparam int                  PASS_W      = $clog2(NUM_PLAYERS);
    localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);
    localparam logic [PASS_W-1:0]   LAST_PASS   = PASS_W'(NUM_PLAYERS - 1);
    localparam logic [MOVE_W-1:0]   MOVE_MAX    = {MOVE_W{1'b1}};

    // Elaboration-time sanity checks on the parameter set.
    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 2 ** PLAYER_W) begin : g_bad_players
        $error("othello_turn_ctrl: NUM_PLAYERS out of range for PLAYER_W");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("othello_turn_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_MOVE = 3'd2,
        S_ADVANCE   = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [PASS_W-1:0] pass_cnt_reg;
    logic              forced_pass;
    logic              pass_eff;

`ifdef OTHELLO_TURN_TIMEOUT_EN
    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_reg;

    // An idle turn that reaches its last allowed cycle is treated as a pass.
    assign forced_pass = (state_reg == S_WAIT_MOVE) && (timer_reg == TIMER_LAST) &&
                         !(game_end || ack || pass);
    assign timeout     = forced_pass;

    // Turn timer: zero on each turn entry, counts while the turn is open.
    // Every input (real or forced) leaves S_WAIT_MOVE at TIMER_LAST, so it cannot wrap.
    always_ff @(posedge clock) begin
        if (!reset) begin
            timer_reg <= '0;
        end else if (state_next == S_WAIT_MOVE && state_reg != S_WAIT_MOVE) begin
            timer_reg <= '0;
        end else if (state_reg == S_WAIT_MOVE) begin
            timer_reg <= timer_reg + TIMER_W'(1);
        end
    end
`else
    assign forced_pass = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign pass_eff = pass || forced_pass;

    // Next-state decode; game_end outranks ack, which outranks pass.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (go) state_next = S_ARM;
            S_ARM:       if (!go) state_next = S_WAIT_MOVE;
            S_WAIT_MOVE: begin
                if (game_end) begin
                    state_next = S_DONE;
                end else if (ack) begin
                    state_next = S_ADVANCE;
                end else if (pass_eff) begin
                    state_next = (pass_cnt_reg == LAST_PASS) ? S_DONE : S_ADVANCE;
                end
            end
            S_ADVANCE:   state_next = S_WAIT_MOVE;
            S_DONE:      if (go) state_next = S_ARM;
            default:     state_next = S_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            player       <= '0;
            pass_cnt_reg <= '0;
            move_count   <= '0;
            enable       <= 1'b0;
            turn_start   <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            enable     <= (state_next == S_WAIT_MOVE);
            turn_start <= (state_next == S_WAIT_MOVE) && (state_reg != S_WAIT_MOVE);
            game_over  <= (state_next == S_DONE);
            case (state_reg)
                S_ARM: begin
                    if (!go) begin
                        player       <= '0;
                        pass_cnt_reg <= '0;
                        move_count   <= '0;
                    end
                end
                S_WAIT_MOVE: begin
                    if (!game_end) begin
                        if (ack) begin
                            if (move_count != MOVE_MAX) begin
                                move_count <= move_count + MOVE_W'(1);
                            end
                            pass_cnt_reg <= '0;
                        end else if (pass_eff && pass_cnt_reg != LAST_PASS) begin
                            pass_cnt_reg <= pass_cnt_reg + PASS_W'(1);
                        end
                    end
                end
                S_ADVANCE: begin
                    player <= (player == LAST_PLAYER) ? '0 : player + PLAYER_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_othello_turn_ctrl.sv
// tb_othello_turn_ctrl: directed scenarios plus a randomized run checked
// against a game-level reference model (3 players, 4-bit move counter).
module tb_othello_turn_ctrl;

    localparam int N  = 3;
    localparam int PW = 2;
    localparam int MW = 4;
    localparam int TO = 8;
    localparam int MOVE_SAT = (1 << MW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0, ack = 1'b0, pass = 1'b0, game_end = 1'b0;
    logic          enable, turn_start, game_over, timeout;
    logic [PW-1:0] player;
    logic [MW-1:0] move_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: game phase and counters at the level of the rules.
    typedef enum int {M_IDLE, M_ARMED, M_TURN, M_GAP, M_OVER} phase_t;
    phase_t m_phase  = M_IDLE;
    int     m_player = 0;
    int     m_passes = 0;
    int     m_moves  = 0;
    int     m_timer  = 0;
    bit     m_first  = 1'b0;

    othello_turn_ctrl #(
        .NUM_PLAYERS   (N),
        .PLAYER_W      (PW),
        .MOVE_W        (MW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .ack       (ack),
        .pass      (pass),
        .game_end  (game_end),
        .enable    (enable),
        .player    (player),
        .turn_start(turn_start),
        .game_over (game_over),
        .move_count(move_count),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    // Whether the turn timer forces a pass in the current cycle.
    function automatic bit model_forced();
`ifdef OTHELLO_TURN_TIMEOUT_EN
        return (m_phase == M_TURN) && (m_timer == TO - 1) && !(game_end || ack || pass);
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model by one clock using the inputs as currently driven.
    task automatic model_step();
        bit p;
        p = pass || model_forced();
        if (!reset) begin
            m_phase = M_IDLE; m_player = 0; m_passes = 0; m_moves = 0;
            m_timer = 0; m_first = 1'b0;
        end else begin
            m_first = 1'b0;
            case (m_phase)
                M_IDLE:  if (go) m_phase = M_ARMED;
                M_ARMED: if (!go) begin
                    m_phase = M_TURN; m_player = 0; m_passes = 0; m_moves = 0;
                    m_timer = 0; m_first = 1'b1;
                end
                M_TURN: begin
                    m_timer++;
                    if (game_end) m_phase = M_OVER;
                    else if (ack) begin
                        m_moves = (m_moves + 1 > MOVE_SAT) ? MOVE_SAT : m_moves + 1;
                        m_passes = 0; m_phase = M_GAP;
                    end else if (p) begin
                        if (m_passes + 1 == N) m_phase = M_OVER;
                        else begin m_passes++; m_phase = M_GAP; end
                    end
                end
                M_GAP: begin
                    m_player = (m_player + 1) % N;
                    m_phase = M_TURN; m_timer = 0; m_first = 1'b1;
                end
                M_OVER:  if (go) m_phase = M_ARMED;
                default: m_phase = M_IDLE;
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input bit g, input bit a, input bit p, input bit e);
        go = g; ack = a; pass = p; game_end = e;
    endtask

    // One turn: present the inputs for one cycle, then release for one cycle.
    task automatic turn(input bit a, input bit p, input bit e);
        set_in(1'b0, a, p, e);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%0b exp=0", enable); end
        checks++; if (turn_start !== 1'b0) begin failures++; $display("FAIL reset_turn_start got=%0b exp=0", turn_start); end
        checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL reset_game_over got=%0b exp=0", game_over); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
        checks++; if (player !== 2'd0) begin failures++; $display("FAIL reset_player got=%0d exp=0", player); end
        checks++; if (move_count !== 4'd0) begin failures++; $display("FAIL reset_move_count got=%0d exp=0", move_count); end
        reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_start();
        go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (enable !== 1'b0) begin failures++; $display("FAIL start_held_go_enable cyc=%0d got=%0b exp=0", i, enable); end
        end
        go = 1'b0;
        tick();
        checks++; if (enable !== 1'b1) begin failures++; $display("FAIL start_enable got=%0b exp=1", enable); end
        checks++; if (turn_start !== 1'b1) begin failures++; $display("FAIL start_turn_start got=%0b exp=1", turn_start); end
        checks++; if (player !== 2'd0) begin failures++; $display("FAIL start_player got=%0d exp=0", player); end
        tick();
        checks++; if (turn_start !== 1'b0) begin failures++; $display("FAIL start_turn_start_pulse got=%0b exp=0", turn_start); end
        checks++; if (enable !== 1'b1) begin failures++; $display("FAIL start_enable_hold got=%0b exp=1", enable); end
        $display("test_start done");
    endtask

    task automatic test_round_robin();
        for (int t = 0; t < 4; t++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            checks++; if (enable !== 1'b0) begin failures++; $display("FAIL rr_gap_enable turn=%0d got=%0b exp=0", t, enable); end
            set_in(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            checks++; if (enable !== 1'b1 || turn_start !== 1'b1) begin failures++; $display("FAIL rr_next_turn turn=%0d enable=%0b turn_start=%0b exp=1,1", t, enable, turn_start); end
            checks++; if (player !== 2'((t + 1) % N)) begin failures++; $display("FAIL rr_player turn=%0d got=%0d exp=%0d", t, player, (t + 1) % N); end
        end
        checks++; if (move_count !== 4'd4) begin failures++; $display("FAIL rr_move_count got=%0d exp=4", move_count); end
        $display("test_round_robin done player=%0d moves=%0d", player, move_count);
    endtask

    task automatic test_pass_end();
        // From player 1, 4 moves: pass, ack, pass, pass, pass.
        turn(1'b0, 1'b1, 1'b0);
        turn(1'b1, 1'b0, 1'b0);
        turn(1'b0, 1'b1, 1'b0);
        turn(1'b0, 1'b1, 1'b0);
        checks++; if (game_over !== 1'b0 || player !== 2'd2 || move_count !== 4'd5) begin failures++; $display("FAIL pass_midgame over=%0b player=%0d moves=%0d exp=0,2,5", game_over, player, move_count); end
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (game_over !== 1'b1 || enable !== 1'b0) begin failures++; $display("FAIL pass_all_end over=%0b enable=%0b exp=1,0", game_over, enable); end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'(i == 0), 1'(i == 1), 1'b0);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (game_over !== 1'b1 || player !== 2'd2 || move_count !== 4'd5) begin failures++; $display("FAIL pass_frozen over=%0b player=%0d moves=%0d exp=1,2,5", game_over, player, move_count); end
        $display("test_pass_end done");
    endtask

    task automatic test_restart();
        go = 1'b1; tick();
        go = 1'b0; tick();
        checks++; if (game_over !== 1'b0 || player !== 2'd0 || move_count !== 4'd0 || turn_start !== 1'b1) begin failures++; $display("FAIL restart over=%0b player=%0d moves=%0d ts=%0b exp=0,0,0,1", game_over, player, move_count, turn_start); end
        $display("test_restart done");
    endtask

    task automatic test_priority();
        turn(1'b0, 1'b1, 1'b0);
        turn(1'b0, 1'b1, 1'b0);
        turn(1'b1, 1'b1, 1'b0);
        checks++; if (move_count !== 4'd1 || game_over !== 1'b0) begin failures++; $display("FAIL prio_ack_pass moves=%0d over=%0b exp=1,0", move_count, game_over); end
        turn(1'b0, 1'b1, 1'b0);
        turn(1'b0, 1'b1, 1'b0);
        checks++; if (game_over !== 1'b0 || player !== 2'd2) begin failures++; $display("FAIL prio_pass_cnt_cleared over=%0b player=%0d exp=0,2", game_over, player); end
        set_in(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (game_over !== 1'b1 || move_count !== 4'd1) begin failures++; $display("FAIL prio_ack_game_end over=%0b moves=%0d exp=1,1", game_over, move_count); end
        $display("test_priority done");
    endtask

    task automatic test_midgame_reset();
        go = 1'b1; tick();
        go = 1'b0; tick();
        for (int i = 0; i < 5; i++) turn(1'b1, 1'b0, 1'b0);
        turn(1'b0, 1'b1, 1'b0);
        turn(1'b0, 1'b1, 1'b0);
        checks++; if (player !== 2'd1 || move_count !== 4'd5) begin failures++; $display("FAIL mid_setup player=%0d moves=%0d exp=1,5", player, move_count); end
        reset = 1'b0; tick();
        reset = 1'b1;
        checks++; if (enable !== 1'b0 || turn_start !== 1'b0 || game_over !== 1'b0 || timeout !== 1'b0 || player !== 2'd0 || move_count !== 4'd0) begin failures++; $display("FAIL mid_reset en=%0b ts=%0b over=%0b to=%0b player=%0d moves=%0d exp=all0", enable, turn_start, game_over, timeout, player, move_count); end
        tick();
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL mid_reset_idle enable=%0b exp=0", enable); end
        $display("test_midgame_reset done");
    endtask

    task automatic test_saturation();
        go = 1'b1; tick();
        go = 1'b0; tick();
        for (int i = 0; i < MOVE_SAT + 2; i++) turn(1'b1, 1'b0, 1'b0);
        checks++; if (move_count !== 4'(MOVE_SAT)) begin failures++; $display("FAIL sat_move_count got=%0d exp=%0d", move_count, MOVE_SAT); end
        checks++; if (player !== 2'((MOVE_SAT + 2) % N)) begin failures++; $display("FAIL sat_player got=%0d exp=%0d", player, (MOVE_SAT + 2) % N); end
        $display("test_saturation done");
    endtask

    task automatic test_idle_turn();
        int bad;
        bad = 0;
`ifdef OTHELLO_TURN_TIMEOUT_EN
        // Currently in cycle 1 of a turn; cycle TO must carry the timeout pulse.
        for (int i = 1; i < TO; i++) begin
            checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_early cyc=%0d got=%0b exp=0", i, timeout); end
            tick();
        end
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_pulse got=%0b exp=1", timeout); end
        tick(); tick();
        checks++; if (player !== 2'(((MOVE_SAT + 2) % N + 1) % N) || turn_start !== 1'b1) begin failures++; $display("FAIL to_advance player=%0d ts=%0b", player, turn_start); end
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (enable !== 1'b1 || timeout !== 1'b0 || player !== 2'((MOVE_SAT + 2) % N)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL idle_no_timeout bad_cycles=%0d exp=0", bad); end
`endif
        $display("test_idle_turn done");
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) != 0);
            go       = ($urandom_range(0, 9) == 0);
            ack      = ($urandom_range(0, 3) == 0);
            pass     = ($urandom_range(0, 4) == 0);
            game_end = ($urandom_range(0, 29) == 0);
            #1;
            checks++;
            if (timeout !== model_forced()) begin
                failures++;
                if (bad++ < 10) $display("FAIL rand_timeout cyc=%0d got=%0b exp=%0b", i, timeout, model_forced());
            end
            tick();
            checks++;
            if (enable !== (m_phase == M_TURN) || turn_start !== m_first || game_over !== (m_phase == M_OVER) ||
                player !== PW'(m_player) || move_count !== MW'(m_moves)) begin
                failures++;
                if (bad++ < 10) $display("FAIL rand_outputs cyc=%0d got en=%0b ts=%0b over=%0b pl=%0d mv=%0d exp en=%0b ts=%0b over=%0b pl=%0d mv=%0d",
                    i, enable, turn_start, game_over, player, move_count,
                    m_phase == M_TURN, m_first, m_phase == M_OVER, m_player, m_moves);
            end
        end
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        $display("test_random done mismatching_cycles=%0d", bad);
    endtask

    initial begin
        #2;
        test_reset();
        test_start();
        test_round_robin();
        test_pass_end();
        test_restart();
        test_priority();
        test_midgame_reset();
        test_saturation();
        test_idle_turn();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
